// File: rtl/router_pkg.sv
// Shared router constants, the header-length extractor and the pop classification
// used by the per-destination packet FIFOs.
package router_pkg;

  localparam int ROUTER_DATA_WIDTH = 8;
  localparam int ROUTER_LEN_LSB    = 2;
  localparam int ROUTER_LEN_WIDTH  = 6;
  localparam int HDR_W_MAX         = 64;

  // What an accepted pop does to the packet tracker.
  typedef enum logic [1:0] {
    POP_NONE   = 2'd0,
    POP_HDR    = 2'd1,
    POP_BODY   = 2'd2,
    POP_ORPHAN = 2'd3
  } pop_kind_e;

  // Header length field, returned zero-extended; callers truncate to their field width.
  function automatic logic [HDR_W_MAX-1:0] hdr_len(input logic [HDR_W_MAX-1:0] word,
                                                   input int lsb,
                                                   input int width);
    return (word >> lsb) & ((HDR_W_MAX'(1) << width) - HDR_W_MAX'(1));
  endfunction

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Handshake and status bundle between a router core and one packet FIFO.
interface router_fifo_pkt_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int DEPTH      = 16
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write_enb;
  logic                  sof;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  pkt_active;
  logic                  pkt_done;
  logic                  framing_err;

  modport master (
    output write_enb, sof, data_in, read_enb,
    input  data_out, data_valid, full, empty, almost_full, count,
           pkt_active, pkt_done, framing_err
  );

  modport slave (
    input  write_enb, sof, data_in, read_enb,
    output data_out, data_valid, full, empty, almost_full, count,
           pkt_active, pkt_done, framing_err
  );

endinterface

// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO: stores {sof, data} per entry and tracks the
// remaining length of the packet being drained, flagging framing errors.
module router_fifo_pkt
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int LEN_LSB    = ROUTER_LEN_LSB,
  parameter int LEN_WIDTH  = ROUTER_LEN_WIDTH,
  parameter int AF_MARGIN  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    soft_reset,
  router_fifo_pkt_if.slave        bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = PW + 1;
  localparam int RW = LEN_WIDTH + 1;
  localparam int EW = DATA_WIDTH + 1;

  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]         remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  framing_err_q, framing_err_d;

  logic                  clr;
  logic                  full_w, empty_w, push, pop;
  logic [PW-1:0]         count_w;
  logic [FW-1:0]         free_w;
  logic [EW-1:0]         rd_word;
  pop_kind_e             pop_kind;

  assign clr = reset | soft_reset;

  // Occupancy comes straight from the wrap-extended pointers.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign free_w  = FW'(DEPTH) - {1'b0, count_w};

  assign push    = bus.write_enb & ~full_w;
  assign pop     = bus.read_enb & ~empty_w;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pop_kind = POP_NONE;
    if (pop) begin
      if (rd_word[DATA_WIDTH])    pop_kind = POP_HDR;
      else if (remaining_q != '0) pop_kind = POP_BODY;
      else                        pop_kind = POP_ORPHAN;
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    remaining_d   = remaining_q;
    pkt_done_d    = 1'b0;
    framing_err_d = framing_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      data_out_d   = rd_word[DATA_WIDTH-1:0];
      data_valid_d = 1'b1;
    end

    // The +1 on a header reload accounts for the trailing parity word.
    unique case (pop_kind)
      POP_HDR: begin
        remaining_d = RW'(hdr_len(HDR_W_MAX'(rd_word[DATA_WIDTH-1:0]), LEN_LSB, LEN_WIDTH))
                      + RW'(1);
        if (remaining_q != '0) framing_err_d = 1'b1;
      end
      POP_BODY: begin
        remaining_d = remaining_q - RW'(1);
        pkt_done_d  = (remaining_q == RW'(1));
      end
      POP_ORPHAN: framing_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      remaining_q   <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      pkt_done_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      remaining_q   <= remaining_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      pkt_done_q    <= pkt_done_d;
      framing_err_q <= framing_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.sof, bus.data_in};
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = (free_w <= FW'(AF_MARGIN));
  assign bus.count       = count_w;
  assign bus.pkt_active  = (remaining_q != '0);
  assign bus.pkt_done    = pkt_done_q;
  assign bus.framing_err = framing_err_q;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed and randomized bench for router_fifo_pkt against a queue-based packet model.
module tb_router_fifo_pkt;

  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset, soft_reset;
  always #5 clock = ~clock;

  router_fifo_pkt_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus ();

  router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(DEPTH), .LEN_LSB(2), .LEN_WIDTH(6), .AF_MARGIN(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [8:0] q[$];
  int         m_rem;
  bit         m_err, m_done, m_valid;
  logic [7:0] m_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit sr, input bit we, input bit s,
                      input logic [7:0] d, input bit re);
    bit         full_m, empty_m;
    logic [8:0] w;
    reset = rs; soft_reset = sr;
    bus.write_enb = we; bus.sof = s; bus.data_in = d; bus.read_enb = re;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    if (rs || sr) begin
      q.delete(); m_rem = 0; m_err = 0; m_done = 0; m_valid = 0; m_dout = 8'h00;
    end else begin
      m_done = 0; m_valid = 0;
      if (re && !empty_m) begin
        w = q.pop_front();
        m_dout = w[7:0]; m_valid = 1;
        if (w[8]) begin
          if (m_rem != 0) m_err = 1;
          m_rem = ((int'(w[7:0]) >> 2) & 63) + 1;
        end else if (m_rem != 0) begin
          if (m_rem == 1) m_done = 1;
          m_rem--;
        end else m_err = 1;
      end
      if (we && !full_m) q.push_back({s, d});
    end
    @(posedge clock); #1;
    check("data_valid",  32'(bus.data_valid),  32'(m_valid));
    check("data_out",    32'(bus.data_out),    32'(m_dout));
    check("count",       32'(bus.count),       32'(q.size()));
    check("full",        32'(bus.full),        32'(q.size() == DEPTH));
    check("empty",       32'(bus.empty),       32'(q.size() == 0));
    check("almost_full", 32'(bus.almost_full), 32'((DEPTH - q.size()) <= 2));
    check("pkt_active",  32'(bus.pkt_active),  32'(m_rem != 0));
    check("pkt_done",    32'(bus.pkt_done),    32'(m_done));
    check("framing_err", 32'(bus.framing_err), 32'(m_err));
  endtask

  task automatic push(input bit s, input logic [7:0] d); step(0, 0, 1, s, d, 0); endtask
  task automatic pop();                                  step(0, 0, 0, 0, 8'h00, 1); endtask
  task automatic idle();                                 step(0, 0, 0, 0, 8'h00, 0); endtask

  initial begin
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 1, 1, 8'hAA, 1);
    idle();
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_dout",  32'(bus.data_out), 32'd0);

    // Header len=3 followed by four body words
    push(1, 8'h0C); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    pop();
    check("hdr_dout", 32'(bus.data_out), 32'h0C);
    check("hdr_active", 32'(bus.pkt_active), 32'd1);
    pop(); pop(); pop(); pop();
    check("last_dout", 32'(bus.data_out), 32'h44);
    check("last_done", 32'(bus.pkt_done), 32'd1);
    idle();

    // Fill, overflow attempt, drain across the wrap
    for (int i = 0; i < DEPTH; i++) push(i == 0, 8'(8'h80 + i));
    check("fill_full", 32'(bus.full), 32'd1);
    push(0, 8'hEE);
    check("fill_count", 32'(bus.count), 32'd16);
    step(0, 0, 1, 0, 8'hDD, 1);
    check("full_pushpop_count", 32'(bus.count), 32'd15);
    for (int i = 0; i < DEPTH; i++) pop();
    step(0, 0, 1, 1, 8'h04, 1);
    check("empty_pushpop_valid", 32'(bus.data_valid), 32'd0);
    check("empty_pushpop_count", 32'(bus.count), 32'd1);

    // Header popped while a packet is still open
    step(0, 1, 0, 0, 8'h00, 0);
    push(1, 8'h04); push(1, 8'h08); pop(); pop();
    check("hdr_overlap_err", 32'(bus.framing_err), 32'd1);
    idle(); idle();
    step(0, 1, 0, 0, 8'h00, 0);
    push(0, 8'h55); pop();
    check("orphan_err", 32'(bus.framing_err), 32'd1);

    // Flush mid-packet with a same-cycle push
    step(0, 1, 0, 0, 8'h00, 0);
    push(1, 8'h0C);
    for (int i = 0; i < 7; i++) push(0, 8'(i));
    pop();
    check("mid_count", 32'(bus.count), 32'd7);
    step(0, 1, 1, 0, 8'h99, 0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_active", 32'(bus.pkt_active), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step(0, ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
- Parametrised, packet-aware synchronous FIFO. It is the next-generation per-destination buffer between the router synchroniser/FSM and each output port.
- Stores a header flag alongside every data word and tracks the remaining length of the packet being read from the header's length field.
- Adds explicit output valid, occupancy count, almost-full watermark, flush and framing-error detection.
- Tri-stated outputs are not used.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- LEN_LSB, 2, LSB of the payload-length field within a header word.
- LEN_WIDTH, 6, width of the payload-length field; LEN_LSB+LEN_WIDTH <= DATA_WIDTH.
- AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- soft_reset, input, 1, synchronous flush; same effect as reset on all state.
- write_enb, input, 1, push request.
- sof, input, 1, the pushed word is a packet header.
- data_in, input, DATA_WIDTH, push data.
- read_enb, input, 1, pop request.
- data_out, output, DATA_WIDTH, registered pop data.
- data_valid, output, 1, data_out holds a word popped on the previous edge.
- full, output, 1, combinational: count == DEPTH.
- empty, output, 1, combinational: count == 0.
- almost_full, output, 1, combinational: DEPTH-count <= AF_MARGIN.
- count, output, $clog2(DEPTH)+1, current occupancy.
- pkt_active, output, 1, remaining != 0, i.e. a packet is partially read.
- pkt_done, output, 1, one-cycle pulse on the pop that brings remaining from 1 to 0.
- framing_err, output, 1, sticky error flag.

Behaviour:
- Reset or soft_reset (equal priority, both synchronous): pointers, count and remaining are cleared.
  - data_out=0, data_valid=0, pkt_done=0, framing_err=0.
  - Memory contents are don't-care.
  - This overrides any same-cycle push or pop, including mid-packet.
- Storage: DEPTH entries of DATA_WIDTH+1 bits, holding {sof, data_in}.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes wrap.
  - full = MSBs differ and lower bits are equal; empty = pointers equal; count = wr_ptr - rd_ptr, modulo.
- Push accepted = write_enb & ~full, with full evaluated before the edge. A push while full is dropped and no state changes.
- Pop accepted = read_enb & ~empty.
  - data_out is loaded with the stored data at the edge and data_valid=1 for the following cycle: one-cycle latency.
  - With no accepted pop, data_valid=0 and data_out holds its last value.
- Simultaneous push and pop:
  - Both are accepted if their conditions hold and count is unchanged.
  - When full, only the pop occurs. When empty, only the push occurs; no write-through/bypass.
  - A word becomes poppable the cycle after it is pushed.
- Packet tracking, on an accepted pop:
  - Stored sof=1: remaining <= len+1, where len = data[LEN_LSB +: LEN_WIDTH] and +1 counts parity. If remaining was !=0 beforehand, framing_err <= 1.
  - Stored sof=0 with remaining !=0: remaining <= remaining-1; pkt_done pulses when remaining was 1.
  - Stored sof=0 with remaining ==0: framing_err <= 1 (orphan word); remaining stays 0.
  - remaining is LEN_WIDTH+1 bits, so a maximum len of 2^LEN_WIDTH-1 gives 2^LEN_WIDTH, with no overflow.
- framing_err clears only on reset or soft_reset.
- Pointer wrap: natural binary rollover of the full-width pointers. No special case at DEPTH-1 -> 0.

Decomposition:
- Shared package router_pkg holds the default DATA_WIDTH, LEN_LSB and LEN_WIDTH constants, and a function for the header-length extract.
- No sub-module is needed. Storage is an inferred register array inside router_fifo_pkt, so the pointer/count logic stays adjacent to the packet tracker.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, data_valid=0, data_out=0, framing_err=0.
- Push header 0x0C (len=3), then 0x11, 0x22, 0x33, 0x44; pop 5 -> data_out sequence 0C,11,22,33,44, each valid one cycle after its pop. pkt_active=1 after the header pop; pkt_done pulses with the 0x44 pop; count returns to 0.
- Fill 16 words -> full=1, almost_full=1 from count=14. A 17th push is ignored. Pop all 16 -> original order, wrap correct, empty=1.
- At count=16, push+pop in the same cycle -> count=15, the pushed word is lost. At count=0, push+pop -> count=1, data_valid=0 next cycle.
- Pop a header while remaining=2, and separately pop an orphan payload word -> framing_err=1 and stays set until soft_reset.
- soft_reset mid-packet (count=7, remaining=4) with a simultaneous push -> next cycle count=0, pkt_active=0, data_valid=0, framing_err=0.
